keypad_key_filter: RTL
======================

Name: keypad_key_filter

Overview:
- Sits between the keypad poller/encoder pair and the calculator control FSM.
- Synchronises and debounces the raw `key_pressed` level and its 4-bit keycode.
- Emits exactly one registered single-cycle `key_valid` strobe per physical keypress, with a stable `key_code`, so the consumer needs no edge detection of its own.
- Also reports release events, a held level, and a wrapping keypress counter for LED debug.

Parameters:
- DEBOUNCE_CYCLES, 240000, stable-sample count required to accept a press or a release (20 ms at 12 MHz); legal range 2..2^CNT_W-1.
- CNT_W, 18, debounce counter width.

Ports:
- Clk  in  1  system clock (12 MHz)
- reset  in  1  asynchronous, active-low reset
- raw_pressed  in  1  key-down level from keypad poller; asynchronous to Clk and may bounce
- raw_code  in  4  keycode from keypad encoder, 0-9 digits, A-F function keys
- key_valid  out  1  one-cycle strobe: debounced press accepted
- key_code  out  4  code of the last accepted press; stable until the next accepted press
- key_held  out  1  high while the accepted key is considered down
- key_released  out  1  one-cycle strobe: debounced release accepted
- event_count  out  8  count of accepted presses, wraps 255->0

Behaviour:
- Reset is asynchronous, active-low; clock is Clk.
- Reset values: all outputs 0, state IDLE, counter 0, synchronisers 0.
- Reset asserted mid-operation returns to IDLE immediately. No strobe is emitted on reset entry or exit.
- Input sync: raw_pressed and raw_code pass through a 2-flop synchroniser (`sp`, `sc`). All FSM decisions use `sp`/`sc`.
- FSM states: IDLE, DEB_PRESS, PRESSED, DEB_RELEASE.
- IDLE:
  - sp=1 -> capture cand<=sc, cnt<=0, go to DEB_PRESS.
- DEB_PRESS:
  - sp=0 -> IDLE (bounce rejected, no output).
  - sc!=cand -> cand<=sc, cnt<=0, stay (code changed, restart window).
  - Otherwise, if cnt==DEBOUNCE_CYCLES-1 -> go to PRESSED; key_code<=cand, key_valid<=1, key_held<=1, event_count<=event_count+1.
  - Otherwise cnt<=cnt+1.
- PRESSED:
  - sp=0 -> cnt<=0, go to DEB_RELEASE.
  - sc changes while held are ignored; key_code does not move.
- DEB_RELEASE:
  - sp=1 -> PRESSED (release bounce). No new key_valid; key_held stays 1.
  - Otherwise, if cnt==DEBOUNCE_CYCLES-1 -> go to IDLE; key_held<=0, key_released<=1.
  - Otherwise cnt<=cnt+1.
- Strobes: key_valid and key_released are registered and high for exactly one cycle; they default to 0 in every other cycle. They are never high in the same cycle.
- Latency: with raw_pressed first sampled high at rising edge 1 and held stable with a constant code, key_valid is high in the cycle after edge DEBOUNCE_CYCLES+3. The same figure applies for release -> key_released.
- Counter: cnt never exceeds DEBOUNCE_CYCLES-1; no wrap. event_count wraps modulo 256.
- Re-press: a new press is accepted only after a full release has been accepted (state IDLE). A long hold produces one key_valid, with no auto-repeat.
- raw_code is a don't-care whenever sp=0.

Test Plan (DEBOUNCE_CYCLES=8 unless stated):
- Clean press/release: raw_code=4'h7, raw_pressed high for 40 cycles then low.
  - key_valid is high exactly one cycle, after edge 11; key_code=7; event_count=1.
  - key_held is 1 until key_released pulses 11 edges after the release.
- Press bounce: raw_pressed toggles 1,0,1,0 every 3 cycles, then stays low.
  - No key_valid, no key_released; event_count=0; FSM returns to IDLE.
- Code change during debounce: raw_pressed high, raw_code=4'h3 for 5 cycles, then 4'hE held for 20 cycles.
  - Exactly one key_valid, with key_code=4'hE; it appears 8 cycles after sc shows E, plus sync.
- Release bounce and hold: key 4'hC accepted, then raw_pressed low for 4 cycles, high for 10, then low for 20.
  - Only one key_valid and one key_released; key_held never drops before the final release.
- Reset mid-debounce and wrap:
  - Assert reset in DEB_PRESS at cnt=5 -> all outputs 0 at once, no strobe after deassert while raw_pressed is low.
  - Separately, 256 accepted presses -> event_count returns to 0.
- Long hold, default parameters: DEBOUNCE_CYCLES=240000, 4'h1 held for 1,000,000 cycles.
  - Exactly one key_valid, at edge 240003.

Source files
------------

// File: rtl/keypad_key_filter.sv
// Keypad debounce filter: synchronises the raw press level and keycode, then
// emits one key_valid strobe per debounced press and one key_released per release.
module keypad_key_filter #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int CNT_W           = 18
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       raw_pressed,
    input  logic [3:0] raw_code,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held,
    output logic       key_released,
    output logic [7:0] event_count
);

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        DEB_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sp_meta_q, sp_q;
    logic [3:0]       sc_meta_q, sc_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cand_q, cand_d;
    logic             key_valid_q, key_valid_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_held_q, key_held_d;
    logic             key_released_q, key_released_d;
    logic [7:0]       event_count_q, event_count_d;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        cand_d         = cand_q;
        key_code_d     = key_code_q;
        key_held_d     = key_held_q;
        event_count_d  = event_count_q;
        key_valid_d    = 1'b0;
        key_released_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sp_q) begin
                    cand_d  = sc_q;
                    cnt_d   = '0;
                    state_d = DEB_PRESS;
                end
            end
            DEB_PRESS: begin
                if (!sp_q) begin
                    state_d = IDLE;
                end else if (sc_q != cand_q) begin
                    // A code change means a different key: restart the window.
                    cand_d = sc_q;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = PRESSED;
                    key_code_d    = cand_q;
                    key_valid_d   = 1'b1;
                    key_held_d    = 1'b1;
                    event_count_d = event_count_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!sp_q) begin
                    cnt_d   = '0;
                    state_d = DEB_RELEASE;
                end
            end
            DEB_RELEASE: begin
                if (sp_q) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d        = IDLE;
                    key_held_d     = 1'b0;
                    key_released_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            sp_meta_q      <= 1'b0;
            sp_q           <= 1'b0;
            sc_meta_q      <= 4'd0;
            sc_q           <= 4'd0;
            state_q        <= IDLE;
            cnt_q          <= '0;
            cand_q         <= 4'd0;
            key_valid_q    <= 1'b0;
            key_code_q     <= 4'd0;
            key_held_q     <= 1'b0;
            key_released_q <= 1'b0;
            event_count_q  <= 8'd0;
        end else begin
            sp_meta_q      <= raw_pressed;
            sp_q           <= sp_meta_q;
            sc_meta_q      <= raw_code;
            sc_q           <= sc_meta_q;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            cand_q         <= cand_d;
            key_valid_q    <= key_valid_d;
            key_code_q     <= key_code_d;
            key_held_q     <= key_held_d;
            key_released_q <= key_released_d;
            event_count_q  <= event_count_d;
        end
    end

    assign key_valid    = key_valid_q;
    assign key_code     = key_code_q;
    assign key_held     = key_held_q;
    assign key_released = key_released_q;
    assign event_count  = event_count_q;

endmodule
